hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage MIPS pipeline. Sits beside the forwarding unit and sequences the front end. It stalls PC and IF/ID on load-use hazards, squashes IF/ID and ID/EX on taken branches, and holds the pipe while the multi-cycle mult/div unit runs. It also keeps saturating stall and flush statistics counters.

---
 rtl/hazard_ctrl_if.sv | 31 +++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard controller signals between the pipeline datapath and hazard_ctrl.
// master: the pipeline/datapath side, slave: the controller.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_md;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic             branch_taken;
  logic             md_done;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             md_go;
  logic             md_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ifid_rs, ifid_rt, ifid_md, idex_memread, idex_rt, branch_taken, md_done,
    input  pc_write, ifid_write, ifid_flush, idex_flush, md_go, md_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_md, idex_memread, idex_rt, branch_taken, md_done,
    output pc_write, ifid_write, ifid_flush, idex_flush, md_go, md_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, taken-branch squash, mult/div hold,
// plus saturating stall and flush counters.
// Optional feature macro MULDIV_STALL_EN: when defined, the MDWAIT state, md_go, md_err and
// the mult/div timeout are built; otherwise ifid_md/md_done are ignored and md_go/md_err are 0.
module hazard_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MD_TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  logic             lu;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             md_go;
  logic             branch_evt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

`ifdef MULDIV_STALL_EN
  localparam int unsigned TMO_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StMdWait} state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             md_issued_q, md_issued_d;
  logic             md_err_q;
  logic             err_set;
`else
  logic unused_md;
  assign unused_md = bus.ifid_md ^ bus.md_done;
`endif

  // Next-state and combinational control outputs; reset forces the pipe into a flushed hold.
  always_comb begin
    lu = bus.idex_memread && (bus.idex_rt != 5'd0) &&
         ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    md_go      = 1'b0;
    branch_evt = 1'b0;
`ifdef MULDIV_STALL_EN
    state_d     = state_q;
    tmo_d       = tmo_q;
    md_issued_d = 1'b0;
    err_set     = 1'b0;
`endif
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
`ifdef MULDIV_STALL_EN
      state_d    = StRun;
    end else if (state_q == StMdWait) begin
      // EX holds a bubble here, so branch_taken cannot be genuine and is ignored.
      if (bus.md_done || (tmo_q == TMO_LAST)) begin
        state_d     = StRun;
        md_issued_d = 1'b1;
        err_set     = !bus.md_done;
      end else begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        tmo_d      = tmo_q + 1'b1;
      end
`endif
    end else if (bus.branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      branch_evt = 1'b1;
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
`ifdef MULDIV_STALL_EN
    end else if (bus.ifid_md && !md_issued_q) begin
      // md_issued_q blocks a restart of the instruction just released from MDWAIT.
      md_go      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      state_d    = StMdWait;
      tmo_d      = '0;
`endif
    end
  end

`ifdef MULDIV_STALL_EN
  // FSM state, timeout counter, one-cycle restart block and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      tmo_q       <= '0;
      md_issued_q <= 1'b0;
      md_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      md_issued_q <= md_issued_d;
      md_err_q    <= md_err_q | err_set;
    end
  end

  assign bus.md_go  = md_go;
  assign bus.md_err = md_err_q;
`else
  assign bus.md_go  = 1'b0;
  assign bus.md_err = 1'b0;
`endif

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (branch_evt && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.ifid_write = ifid_write;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.stall_cnt  = stall_q;
  assign bus.flush_cnt  = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a stimulus task drives one cycle at a time and pushes the
// behaviourally predicted response; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned MD_TIMEOUT = 12;
`ifdef MULDIV_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef struct {
    logic [4:0] ctl;  // {pc_write, ifid_write, ifid_flush, idex_flush, md_go}
    logic       err;
    int         sc;
    int         fc;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(
    .CNT_W     (CNT_W),
    .MD_TIMEOUT(MD_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  exp_t got_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model state: counts rather than encodings.
  bit m_wait;     // a mult/div is in flight
  int m_waited;   // stall cycles spent on it so far, including the md_go cycle
  bit m_block;    // the cycle just after a release must not restart an md
  bit m_err;
  int m_stalls;
  int m_flushes;

  task automatic step(input bit r, input bit [4:0] rs, input bit [4:0] rt_id, input bit md,
                      input bit mr, input bit [4:0] ert, input bit br, input bit done);
    exp_t e;
    bit   hz;
    bit   blk;
    int   cmax;
    @(posedge clk);
    #1;
    rst              = r;
    bus.ifid_rs      = rs;
    bus.ifid_rt      = rt_id;
    bus.ifid_md      = md;
    bus.idex_memread = mr;
    bus.idex_rt      = ert;
    bus.branch_taken = br;
    bus.md_done      = done;
    cmax  = (1 << CNT_W) - 1;
    e.sc  = m_stalls;
    e.fc  = m_flushes;
    e.err = m_err;
    e.cyc = cyc;
    blk     = m_block;
    m_block = 1'b0;
    if (r) begin
      e.ctl     = 5'b00110;
      m_wait    = 1'b0;
      m_waited  = 0;
      m_err     = 1'b0;
      m_stalls  = 0;
      m_flushes = 0;
    end else begin
      // A load whose destination is one of the two registers read in ID.
      hz = mr && (ert != 0) && ((ert == rs) || (ert == rt_id));
      if (MD_EN && m_wait) begin
        if (done || (m_waited == int'(MD_TIMEOUT))) begin
          e.ctl   = 5'b11000;
          m_err   = m_err | !done;
          m_wait  = 1'b0;
          m_block = 1'b1;
        end else begin
          e.ctl    = 5'b00010;
          m_waited = m_waited + 1;
        end
      end else if (br) begin
        e.ctl     = 5'b11110;
        m_flushes = (m_flushes < cmax) ? m_flushes + 1 : cmax;
      end else if (hz) begin
        e.ctl = 5'b00010;
      end else if (MD_EN && md && !blk) begin
        e.ctl    = 5'b00011;
        m_wait   = 1'b1;
        m_waited = 1;
      end else begin
        e.ctl = 5'b11000;
      end
      if (!e.ctl[4]) m_stalls = (m_stalls < cmax) ? m_stalls + 1 : cmax;
    end
    q.push_back(e);
    cyc++;
  endtask

  // Monitor: every cycle the DUT presents a full output set, checked against the queue head.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      got_e = q.pop_front();
      checks++;
      if ({bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush, bus.md_go} !==
          got_e.ctl) begin
        failures++;
        $display("FAIL ctl cyc=%0d got=%b exp=%b", got_e.cyc,
                 {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush, bus.md_go},
                 got_e.ctl);
      end
      checks++;
      if (bus.md_err !== got_e.err) begin
        failures++;
        $display("FAIL md_err cyc=%0d got=%b exp=%b", got_e.cyc, bus.md_err, got_e.err);
      end
      checks++;
      if ($isunknown(bus.stall_cnt) || int'(bus.stall_cnt) != got_e.sc) begin
        failures++;
        $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", got_e.cyc, bus.stall_cnt, got_e.sc);
      end
      checks++;
      if ($isunknown(bus.flush_cnt) || int'(bus.flush_cnt) != got_e.fc) begin
        failures++;
        $display("FAIL flush_cnt cyc=%0d got=%0d exp=%0d", got_e.cyc, bus.flush_cnt, got_e.fc);
      end
    end
  end

  initial begin
    bus.ifid_rs      = '0;
    bus.ifid_rt      = '0;
    bus.ifid_md      = 1'b0;
    bus.idex_memread = 1'b0;
    bus.idex_rt      = '0;
    bus.branch_taken = 1'b0;
    bus.md_done      = 1'b0;
    // Two reset cycles, then release.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0, 0, 0);
    // Load-use on rs, then same with idex_rt = 0, then on rt.
    step(0, 5, 1, 0, 1, 5, 0, 0);
    step(0, 5, 1, 0, 0, 0, 0, 0);
    step(0, 0, 7, 0, 1, 0, 0, 0);
    step(0, 3, 9, 0, 1, 9, 0, 0);
    // Branch beats load-use and md.
    step(0, 5, 1, 1, 1, 5, 1, 0);
    // Mult/div completing after 8 cycles of unit time, md held in ID across the release.
    step(0, 1, 2, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 2, 1, 0, 0, 1, 0);
    step(0, 1, 2, 1, 0, 0, 0, 1);
    step(0, 1, 2, 1, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0, 0, 0);
    // Mult/div that never completes.
    step(0, 1, 2, 1, 0, 0, 0, 0);
    for (int i = 0; i < int'(MD_TIMEOUT) + 2; i++) step(0, 1, 2, 0, 0, 0, 0, 0);
    // Fresh counters, then hold a load-use long enough to saturate stall_cnt.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 4, 0, 0, 1, 4, 0, 0);
    // Branch storm to saturate flush_cnt.
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 249) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
